wptr_full_ctrl: RTL and testbench

Write-domain pointer and full-flag controller for the asynchronous FIFO. It sits directly downstream of the read-to-write pointer synchronizer and consumes the two-stage-synchronized Gray read pointer. From it, the block produces the write address, the Gray write pointer sent to the read domain, and registered full, almost-full and level status. Every output is registered and clocked only by the write clock.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_gray2bin.sv | 15 +
 rtl/wptr_full_ctrl.sv | 85 ++++++++
 tb/tb_wptr_full_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type, Gray helpers.
package fifo_pkg;

   localparam int FIFO_ADDRSIZE = 4;

   typedef logic [FIFO_ADDRSIZE:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return (b >> 1) ^ b;
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = '0;
      for (int i = 0; i <= FIFO_ADDRSIZE; i++)
         b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of arbitrary width.
module fifo_gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++)
         bin[i] = ^(gray >> i);
   end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, full/almost-full and level tracking for the async FIFO.
// Optional sticky overflow flag (wovf/wovf_clr) enabled by FIFO_WOVF_EN.
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE     = FIFO_ADDRSIZE,
   parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                winc,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
`ifdef FIFO_WOVF_EN
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf,
   input  logic                wovf_clr
`else
   output logic [ADDRSIZE:0]   wlevel
`endif
);

   localparam logic [ADDRSIZE:0] AF_TH = AFULL_THRESH[ADDRSIZE:0];

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] wlevel_next;
   logic [ADDRSIZE:0] full_cmp;
   logic              push;
   logic              wfull_next;
   logic              walmost_full_next;

   fifo_gray2bin #(
      .WIDTH (ADDRSIZE + 1)
   ) u_rptr_g2b (
      .gray (wq2_rptr),
      .bin  (rbin)
   );

   assign push      = winc & ~wfull;
   assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, push};
   assign wgraynext = (wbinnext >> 1) ^ wbinnext;
   assign waddr     = wbin[ADDRSIZE-1:0];

   // Full when the write pointer has lapped the read pointer exactly once.
   assign full_cmp   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                        wq2_rptr[ADDRSIZE-2:0]};
   assign wfull_next = (wgraynext == full_cmp);

   assign wlevel_next       = wbinnext - rbin;
   assign walmost_full_next = (wlevel_next >= AF_TH);

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
      end else begin
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= wfull_next;
         walmost_full <= walmost_full_next;
         wlevel       <= wlevel_next;
      end
   end

`ifdef FIFO_WOVF_EN
   always_ff @(posedge wclk) begin
      if (!wrst_n)
         wovf <= 1'b0;
      else if (winc & wfull)
         wovf <= 1'b1;
      else if (wovf_clr)
         wovf <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl at ADDRSIZE=4, AFULL_THRESH=14.
module tb_wptr_full_ctrl;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       winc;
   logic [4:0] wq2_rptr;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wlevel;
   logic       wovf_clr;
`ifdef FIFO_WOVF_EN
   logic       wovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 wclk = ~wclk;

   wptr_full_ctrl #(
      .ADDRSIZE     (4),
      .AFULL_THRESH (14)
   ) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
`ifdef FIFO_WOVF_EN
      .wlevel       (wlevel),
      .wovf         (wovf),
      .wovf_clr     (wovf_clr)
`else
      .wlevel       (wlevel)
`endif
   );

   typedef struct {
      logic       rst_n;
      logic       winc;
      logic       clr;
      logic [4:0] rptr;
      logic [3:0] waddr;
      logic [4:0] wptr;
      logic       full;
      logic       af;
      logic [4:0] lvl;
      logic       ovf;
   } vec_t;

   function automatic logic [4:0] gray5(input int x);
      logic [4:0] b;
      b = x[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      wrst_n   = v.rst_n;
      winc     = v.winc;
      wovf_clr = v.clr;
      wq2_rptr = v.rptr;
      @(posedge wclk);
      #1;
      chk({tag, " waddr"}, int'(waddr), int'(v.waddr));
      chk({tag, " wptr"}, int'(wptr), int'(v.wptr));
      chk({tag, " wfull"}, int'(wfull), int'(v.full));
      chk({tag, " walmost_full"}, int'(walmost_full), int'(v.af));
      chk({tag, " wlevel"}, int'(wlevel), int'(v.lvl));
`ifdef FIFO_WOVF_EN
      chk({tag, " wovf"}, int'(wovf), int'(v.ovf));
`endif
   endtask

   function automatic vec_t mk(input logic r, input logic w,
                               input logic c, input int rp,
                               input int wr, input int rd,
                               input logic ovf);
      vec_t v;
      int   lvl;
      lvl     = (wr - rd) & 31;
      v.rst_n = r;
      v.winc  = w;
      v.clr   = c;
      v.rptr  = gray5(rp);
      v.waddr = 4'(wr & 15);
      v.wptr  = gray5(wr);
      v.full  = (lvl == 16);
      v.af    = (lvl >= 14);
      v.lvl   = 5'(lvl);
      v.ovf   = ovf;
      return v;
   endfunction

   vec_t head [3];
   vec_t tail [6];

   initial begin
      int wr;
      int rd;

      // rst_n winc clr rptr | waddr wptr full af lvl ovf
      head[0] = '{1'b0, 1'b1, 1'b0, 5'b00000,
                  4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0};
      head[1] = '{1'b0, 1'b1, 1'b0, 5'b00000,
                  4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0};
      head[2] = '{1'b1, 1'b1, 1'b0, 5'b00000,
                  4'd1, 5'b00001, 1'b0, 1'b0, 5'd1, 1'b0};

      // Drain from full, then simultaneous push + read advance.
      tail[0] = '{1'b1, 1'b0, 1'b0, 5'b00001,
                  4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b0};
      tail[1] = '{1'b1, 1'b0, 1'b0, 5'b00011,
                  4'd0, 5'b11000, 1'b0, 1'b1, 5'd14, 1'b0};
      tail[2] = '{1'b1, 1'b0, 1'b0, 5'b00010,
                  4'd0, 5'b11000, 1'b0, 1'b0, 5'd13, 1'b0};
      tail[3] = '{1'b1, 1'b1, 1'b0, 5'b00010,
                  4'd1, 5'b11001, 1'b0, 1'b1, 5'd14, 1'b0};
      tail[4] = '{1'b1, 1'b1, 1'b0, 5'b00010,
                  4'd2, 5'b11011, 1'b0, 1'b1, 5'd15, 1'b0};
      tail[5] = '{1'b1, 1'b1, 1'b0, 5'b00110,
                  4'd3, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0};

      wrst_n   = 1'b0;
      winc     = 1'b0;
      wovf_clr = 1'b0;
      wq2_rptr = '0;

      for (int i = 0; i < 3; i++)
         apply(head[i], $sformatf("head%0d", i));

      for (int k = 2; k <= 16; k++)
         apply(mk(1'b1, 1'b1, 1'b0, 0, k, 0, 1'b0),
               $sformatf("fill%0d", k));

      // Blocked write, then overflow set/clear ordering.
      apply(mk(1'b1, 1'b1, 1'b0, 0, 16, 0, 1'b1), "ovf_set");
      apply(mk(1'b1, 1'b1, 1'b1, 0, 16, 0, 1'b1), "ovf_clr_busy");
      apply(mk(1'b1, 1'b0, 1'b1, 0, 16, 0, 1'b0), "ovf_clr_idle");

      for (int i = 0; i < 6; i++)
         apply(tail[i], $sformatf("tail%0d", i));

      // Wrap-around with the read pointer trailing by three.
      apply(mk(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0), "wrap_rst");
      wr = 0;
      rd = 0;
      for (int k = 0; k < 3; k++) begin
         wr++;
         apply(mk(1'b1, 1'b1, 1'b0, rd, wr, rd, 1'b0),
               $sformatf("wrap_pre%0d", k));
      end
      for (int k = 0; k < 40; k++) begin
         wr++;
         apply(mk(1'b1, 1'b1, 1'b0, rd, wr, rd, 1'b0),
               $sformatf("wrap_push%0d", k));
         rd++;
         apply(mk(1'b1, 1'b0, 1'b0, rd, wr, rd, 1'b0),
               $sformatf("wrap_drain%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
